// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial add/subtract unit.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Ceiling log2 with a floor of 1 so a single-digit word still gets a counter bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r = r + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_adder_slice.sv
// One-bit full adder; the top chains DIGIT of these per clock.
module adder_slice (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Digit-serial add/subtract: DIGIT bits per clock, carry held in a flop between digits.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = clog2(N);

  if ((WIDTH % DIGIT) != 0) begin : g_width_check
    $error("serial_adder: WIDTH must be a multiple of DIGIT");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, done_q;

  logic [DIGIT-1:0] dsum;
  logic [DIGIT:0]   chain;

  // Ripple the registered carry through one digit of operand bits.
  assign chain[0] = carry_q;
  for (genvar i = 0; i < int'(DIGIT); i++) begin : g_slice
    adder_slice u_slice (
      .a  (a_q[i]),
      .b  (b_q[i]),
      .ci (chain[i]),
      .s  (dsum[i]),
      .co (chain[i+1])
    );
  end

  // Next-state, operand shifting and result capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? ~cin : cin;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d   = (sum_q >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = chain[DIGIT];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = DONE;
          cout_d  = chain[DIGIT];
          ovf_d   = chain[DIGIT-1] ^ chain[DIGIT];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
  assign zero     = (sum_q == '0);

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench: an 8-bit/1-bit-digit unit and a 32-bit/4-bit-digit unit.
module tb_serial_adder;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, cout8, ovf8, zero8;
  logic [7:0]  sum8;

  logic        start32 = 1'b0, sub32 = 1'b0, cin32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        busy32, done32, cout32, ovf32, zero32;
  logic [31:0] sum32;

  exp_t q8[$];
  exp_t q32[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   last_done32 = -1;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .cin(cin8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .sum(sum8),
    .cout(cout8), .overflow(ovf8), .zero(zero8)
  );

  serial_adder #(.WIDTH(32), .DIGIT(4)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .sub(sub32), .cin(cin32),
    .a(a32), .b(b32), .busy(busy32), .done(done32), .sum(sum32),
    .cout(cout32), .overflow(ovf32), .zero(zero32)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic exp_t mk(input logic [31:0] s, input logic c, input logic v, input logic z);
    exp_t e;
    e.sum = s; e.cout = c; e.ovf = v; e.zero = z;
    return e;
  endfunction

  // Monitor: compare each done pulse against the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && done8) begin
      if (q8.size() == 0) chk("dut8 unexpected done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q8.pop_front();
        chk("dut8 sum", 32'(sum8), e.sum);
        chk("dut8 cout", 32'(cout8), 32'(e.cout));
        chk("dut8 overflow", 32'(ovf8), 32'(e.ovf));
        chk("dut8 zero", 32'(zero8), 32'(e.zero));
        chk("dut8 busy at done", 32'(busy8), 32'd0);
      end
    end
    if (rst_n && done32) begin
      if (q32.size() == 0) chk("dut32 unexpected done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q32.pop_front();
        chk("dut32 sum", sum32, e.sum);
        chk("dut32 cout", 32'(cout32), 32'(e.cout));
        chk("dut32 overflow", 32'(ovf32), 32'(e.ovf));
        chk("dut32 zero", 32'(zero32), 32'(e.zero));
      end
      if (last_done32 >= 0) chk("dut32 done spacing", 32'(cyc - last_done32), 32'd9);
      last_done32 = cyc;
    end
  end

  // Wait for done8 sampled #1 after each edge; returns edges waited, or -1 on timeout.
  task automatic wait_done8(output int k);
    k = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done8) begin k = i; break; end
    end
  endtask

  task automatic wait_done32(output int k);
    k = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done32) begin k = i; break; end
    end
  endtask

  // One 8-bit operation; optionally pokes start/sub/cin/a while running.
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic ts, input logic tc,
                      input exp_t e, input bit disturb);
    int k;
    @(negedge clk);
    a8 = ta; b8 = tb; sub8 = ts; cin8 = tc; start8 = 1'b1;
    q8.push_back(e);
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    chk("dut8 busy after accept", 32'(busy8), 32'd1);
    if (disturb) begin
      @(negedge clk);
      start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; sub8 = ~ts; cin8 = ~tc;
      @(negedge clk);
      @(negedge clk);
      start8 = 1'b0;
      k = 0;
      wait_done8(k);
      chk("dut8 done reached", 32'(k > 0), 32'd1);
    end else begin
      wait_done8(k);
      chk("dut8 accept-to-done edges", 32'(k), 32'd8);
    end
    @(negedge clk);
  endtask

  initial begin
    exp_t v32[8];
    logic [31:0] va[8], vb[8];
    logic        vs[8], vc[8];
    int k;

    repeat (2) @(negedge clk);
    chk("reset busy", 32'(busy8), 32'd0);
    chk("reset done", 32'(done8), 32'd0);
    chk("reset sum", 32'(sum8), 32'd0);
    chk("reset cout", 32'(cout8), 32'd0);
    chk("reset overflow", 32'(ovf8), 32'd0);
    chk("reset zero", 32'(zero8), 32'd1);
    chk("reset zero32", 32'(zero32), 32'd1);
    rst_n = 1'b1;

    run8(8'h0F, 8'h01, 1'b0, 1'b0, mk(32'h10, 1'b0, 1'b0, 1'b0), 1'b0);
    run8(8'h7F, 8'h01, 1'b0, 1'b0, mk(32'h80, 1'b0, 1'b1, 1'b0), 1'b0);
    run8(8'hFF, 8'h01, 1'b0, 1'b0, mk(32'h00, 1'b1, 1'b0, 1'b1), 1'b0);
    run8(8'h05, 8'h07, 1'b1, 1'b0, mk(32'hFE, 1'b0, 1'b0, 1'b0), 1'b0);
    run8(8'h07, 8'h05, 1'b1, 1'b1, mk(32'h01, 1'b1, 1'b0, 1'b0), 1'b0);
    run8(8'h12, 8'h34, 1'b0, 1'b0, mk(32'h46, 1'b0, 1'b0, 1'b0), 1'b1);

    // Abort on the third RUN cycle.
    @(negedge clk);
    a8 = 8'h0F; b8 = 8'h01; sub8 = 1'b0; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", 32'(busy8), 32'd0);
    chk("abort done", 32'(done8), 32'd0);
    chk("abort sum", 32'(sum8), 32'd0);
    chk("abort zero", 32'(zero8), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run8(8'hA5, 8'h5A, 1'b0, 1'b1, mk(32'h00, 1'b1, 1'b0, 1'b1), 1'b0);

    // Back-to-back 32-bit burst with start held high.
    va[0] = 32'h12345678; vb[0] = 32'h11111111; vs[0] = 0; vc[0] = 0; v32[0] = mk(32'h23456789, 0, 0, 0);
    va[1] = 32'hFFFFFFFF; vb[1] = 32'h00000000; vs[1] = 0; vc[1] = 1; v32[1] = mk(32'h00000000, 1, 0, 1);
    va[2] = 32'h7FFFFFFF; vb[2] = 32'h00000001; vs[2] = 0; vc[2] = 0; v32[2] = mk(32'h80000000, 0, 1, 0);
    va[3] = 32'h80000000; vb[3] = 32'h80000000; vs[3] = 0; vc[3] = 0; v32[3] = mk(32'h00000000, 1, 1, 1);
    va[4] = 32'h00000010; vb[4] = 32'h00000001; vs[4] = 1; vc[4] = 0; v32[4] = mk(32'h0000000F, 1, 0, 0);
    va[5] = 32'h00000000; vb[5] = 32'h00000001; vs[5] = 1; vc[5] = 0; v32[5] = mk(32'hFFFFFFFF, 0, 0, 0);
    va[6] = 32'h80000000; vb[6] = 32'h00000001; vs[6] = 1; vc[6] = 0; v32[6] = mk(32'h7FFFFFFF, 1, 1, 0);
    va[7] = 32'hDEADBEEF; vb[7] = 32'h0000BEEF; vs[7] = 1; vc[7] = 1; v32[7] = mk(32'hDEACFFFF, 1, 0, 0);

    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      a32 = va[i]; b32 = vb[i]; sub32 = vs[i]; cin32 = vc[i];
      q32.push_back(v32[i]);
      if (i == 0) begin
        start32 = 1'b1;
        @(posedge clk); #1;
      end
      wait_done32(k);
      if (k < 0) chk("dut32 done timeout", 32'd1, 32'd0);
    end
    start32 = 1'b0;
    repeat (3) @(negedge clk);
    chk("dut32 idle after burst", 32'(busy32), 32'd0);
    chk("dut8 queue drained", 32'(q8.size()), 32'd0);
    chk("dut32 queue drained", 32'(q32.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
